// File: rtl/hist_pkg.sv
// Shared definitions for the histogram counting pipeline: FSM state encoding
// and the default pixel, word and counter widths.
package hist_pkg;

   localparam int PIX_W_DEF  = 8;
   localparam int WORD_W_DEF = 128;
   localparam int CNT_W_DEF  = 16;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_CLEAR  = 3'd1;
   localparam state_t ST_COUNT  = 3'd2;
   localparam state_t ST_DRAIN  = 3'd3;
   localparam state_t ST_FINISH = 3'd4;

endpackage

// File: rtl/hist_pix_unpack.sv
// Pixel extractor: holds one image word, walks its lanes in ascending order and
// prefetches the next word so consecutive words stream with no bubble.
module hist_pix_unpack
   import hist_pkg::*;
#(
   parameter int PIX_W     = PIX_W_DEF,
   parameter int WORD_W    = WORD_W_DEF,
   parameter int NUM_WORDS = 4,
   parameter int ADDR_W    = 16
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              run_i,
   output logic [ADDR_W-1:0] img_rd_addr_o,
   input  logic [WORD_W-1:0] img_rd_data_i,
   output logic [PIX_W-1:0]  pix_o,
   output logic              pix_valid_o,
   output logic              pix_last_o
);

   localparam int PPW    = WORD_W / PIX_W;
   localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PPW - 1);
   localparam logic [ADDR_W:0]   WORDS     = (ADDR_W + 1)'(NUM_WORDS);

   logic [WORD_W-1:0] word_q, word_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic              valid_q, valid_d;
   logic [ADDR_W:0]   next_q, next_d;
   logic              lane_end;
   logic              load;

   assign lane_end = (lane_q == LANE_LAST);
   assign load     = run_i && (!valid_q || lane_end) && (next_q != WORDS);

   // The address always points at the word the next load will capture, so it
   // steps ahead in the same cycle a load happens.
   assign img_rd_addr_o = load ? next_q[ADDR_W-1:0] + 1'b1 : next_q[ADDR_W-1:0];

   assign pix_valid_o = run_i && valid_q;
   assign pix_last_o  = pix_valid_o && lane_end && (next_q == WORDS);

   always_comb begin
      pix_o = '0;
      for (int k = 0; k < PPW; k++) begin
         if (lane_q == LANE_W'(k)) pix_o = word_q[k*PIX_W +: PIX_W];
      end
   end

   always_comb begin
      word_d  = word_q;
      lane_d  = lane_q;
      valid_d = valid_q;
      next_d  = next_q;
      if (!run_i) begin
         lane_d  = '0;
         valid_d = 1'b0;
         next_d  = '0;
      end else begin
         if (valid_q) begin
            lane_d = lane_end ? '0 : lane_q + 1'b1;
            if (lane_end) valid_d = 1'b0;
         end
         if (load) begin
            word_d  = img_rd_data_i;
            valid_d = 1'b1;
            next_d  = next_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         word_q  <= '0;
         lane_q  <= '0;
         valid_q <= 1'b0;
         next_q  <= '0;
      end else begin
         word_q  <= word_d;
         lane_q  <= lane_d;
         valid_q <= valid_d;
         next_q  <= next_d;
      end
   end

endmodule

// File: rtl/hist_count_pipeline.sv
// Histogram builder: streams image pixels through a read/increment/write pipeline
// on an external scratchpad. Define HIST_CLEAR_EN to zero all bins before counting.
module hist_count_pipeline
   import hist_pkg::*;
#(
   parameter int PIX_W     = PIX_W_DEF,
   parameter int WORD_W    = WORD_W_DEF,
   parameter int NUM_WORDS = 4,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int ADDR_W    = 16
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] img_rd_addr,
   input  logic [WORD_W-1:0] img_rd_data,
   output logic [ADDR_W-1:0] sp_rd_addr,
   input  logic [CNT_W-1:0]  sp_rd_data,
   output logic [ADDR_W-1:0] sp_wr_addr,
   output logic [CNT_W-1:0]  sp_wr_data,
   output logic              sp_we,
   output logic              busy,
   output logic              done
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             run;
   logic [PIX_W-1:0] pix;
   logic             pix_valid;
   logic             pix_last;

   logic             ac_valid_q, ac_valid_d;
   logic [PIX_W-1:0] ac_pix_q, ac_pix_d;
   logic             wr_valid_q, wr_valid_d;
   logic [PIX_W-1:0] wr_pix_q, wr_pix_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic             ret_valid_q;
   logic [PIX_W-1:0] ret_pix_q;
   logic [CNT_W-1:0] ret_cnt_q;
   logic [CNT_W-1:0] base_cnt;
`ifdef HIST_CLEAR_EN
   logic [PIX_W-1:0] clr_idx_q, clr_idx_d;
`endif

   assign run = (state_q == ST_COUNT);

   hist_pix_unpack #(
      .PIX_W     (PIX_W),
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS),
      .ADDR_W    (ADDR_W)
   ) u_unpack (
      .clock         (clock),
      .rst_n         (rst_n),
      .run_i         (run),
      .img_rd_addr_o (img_rd_addr),
      .img_rd_data_i (img_rd_data),
      .pix_o         (pix),
      .pix_valid_o   (pix_valid),
      .pix_last_o    (pix_last)
   );

   always_comb begin
      state_d = state_q;
`ifdef HIST_CLEAR_EN
      clr_idx_d = clr_idx_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
`ifdef HIST_CLEAR_EN
               state_d = ST_CLEAR;
`else
               state_d = ST_COUNT;
`endif
            end
         end
`ifdef HIST_CLEAR_EN
         ST_CLEAR: begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == '1) state_d = ST_COUNT;
         end
`endif
         ST_COUNT:  if (pix_last) state_d = ST_DRAIN;
         ST_DRAIN:  if (!ac_valid_q) state_d = ST_FINISH;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Bins written this cycle or last cycle may not be visible in sp_rd_data yet,
   // so the freshest in-flight count for the same bin takes priority.
   always_comb begin
      ac_valid_d = pix_valid;
      ac_pix_d   = pix;
      if (wr_valid_q && (wr_pix_q == ac_pix_q)) base_cnt = wr_cnt_q;
      else if (ret_valid_q && (ret_pix_q == ac_pix_q)) base_cnt = ret_cnt_q;
      else base_cnt = sp_rd_data;
      wr_valid_d = ac_valid_q;
      wr_pix_d   = ac_pix_q;
      wr_cnt_d   = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + 1'b1;
`ifdef HIST_CLEAR_EN
      if (state_q == ST_CLEAR) begin
         wr_valid_d = 1'b1;
         wr_pix_d   = clr_idx_q;
         wr_cnt_d   = '0;
      end
`endif
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ac_valid_q  <= 1'b0;
         ac_pix_q    <= '0;
         wr_valid_q  <= 1'b0;
         wr_pix_q    <= '0;
         wr_cnt_q    <= '0;
         ret_valid_q <= 1'b0;
         ret_pix_q   <= '0;
         ret_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ac_valid_q  <= ac_valid_d;
         ac_pix_q    <= ac_pix_d;
         wr_valid_q  <= wr_valid_d;
         wr_pix_q    <= wr_pix_d;
         wr_cnt_q    <= wr_cnt_d;
         ret_valid_q <= wr_valid_q;
         ret_pix_q   <= wr_pix_q;
         ret_cnt_q   <= wr_cnt_q;
      end
   end

`ifdef HIST_CLEAR_EN
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) clr_idx_q <= '0;
      else        clr_idx_q <= clr_idx_d;
   end
`endif

   assign sp_rd_addr = pix_valid ? ADDR_W'(pix) : '0;
   assign sp_we      = wr_valid_q;
   assign sp_wr_addr = ADDR_W'(wr_pix_q);
   assign sp_wr_data = wr_cnt_q;
   assign busy       = (state_q == ST_CLEAR) || (state_q == ST_COUNT) || (state_q == ST_DRAIN);
   assign done       = (state_q == ST_FINISH);

endmodule

// File: doc/hist_count_pipeline.md
HIST_COUNT_PIPELINE -- requirements
Module: hist_count_pipeline

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits; histogram has 2**PIX_W bins.
REQ-002 Parameter WORD_W, default 128, image-memory word width; PIX_PER_WORD = WORD_W/PIX_W, an integer power of two.
REQ-003 Parameter NUM_WORDS, default 4, image words per frame, range 1..2**ADDR_W.
REQ-004 Parameter CNT_W, default 16, bin counter width.
REQ-005 Parameter ADDR_W, default 16, width of all address ports.
REQ-006 clock  input  1  single clock for all state, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle pulse that starts a frame.
REQ-009 img_rd_addr  output  ADDR_W  image-memory read address.
REQ-010 img_rd_data  input  WORD_W  image word, valid one cycle after its address.
REQ-011 sp_rd_addr  output  ADDR_W  scratchpad read address (bin index, zero-extended).
REQ-012 sp_rd_data  input  CNT_W  bin count, valid one cycle after its address.
REQ-013 sp_wr_addr  output  ADDR_W  scratchpad write address.
REQ-014 sp_wr_data  output  CNT_W  scratchpad write data.
REQ-015 sp_we  output  1  scratchpad write enable.
REQ-016 busy  output  1  high from the cycle after start until done.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 FSM states: IDLE, CLEAR (macro only), COUNT, DRAIN, FINISH; reset state IDLE.
REQ-019 IDLE->COUNT (or CLEAR) on start; start while busy is ignored.
REQ-020 COUNT: one pixel enters per cycle, pixel k of word w taken from bits [k*PIX_W +: PIX_W], k ascending, w ascending from address 0, with no bubble between words (next word prefetched).
REQ-021 Stages: RD (issue sp_rd_addr) -> AC (count+1) -> WR (sp_we=1); a pixel entering in cycle t is written in cycle t+2.
REQ-022 Hazards: if the AC-stage pixel equals the WR-stage pixel, AC uses the WR-stage count instead of sp_rd_data; scratchpad read-during-write of the same address is never relied on.
REQ-023 Increment saturates at 2**CNT_W-1; no wrap.
REQ-024 COUNT->DRAIN after the last pixel enters; DRAIN lasts until the last write retires; then FINISH asserts done=1 and busy=0 for one cycle; FINISH->IDLE.
REQ-025 Total writes per frame = NUM_WORDS*PIX_PER_WORD; sp_we=0 outside writes.

Reset
REQ-026 On rst_n low, immediately: FSM=IDLE, all addresses 0, sp_wr_data 0, sp_we 0, busy 0, done 0, pipeline valids cleared.
REQ-027 Reset mid-frame abandons the frame without further writes; scratchpad contents are undefined.

Configuration
REQ-028 HIST_CLEAR_EN defined: start enters CLEAR, writing 0 to bins 0..2**PIX_W-1, one per cycle, then COUNT; bins read before the clear completes are never used.
REQ-029 HIST_CLEAR_EN undefined: no CLEAR state; bins accumulate onto existing scratchpad contents; the external owner pre-clears.

Structure
REQ-030 Shared package hist_pkg holds the FSM state typedef and the default PIX_W/WORD_W/CNT_W constants.
REQ-031 The pixel extractor (word register, lane index, prefetch request) is sub-module hist_pix_unpack.

Verification
REQ-032 Defaults, cleared scratchpad, 4 words all 0x05 -> bin 5 = 64, 64 writes, done once, busy 0 afterwards.
REQ-033 Pixels alternating 0x01,0x02 across 64 pixels -> bins 1 and 2 = 32 each (forwarding at distance 2).
REQ-034 CNT_W=4, 1 word of 16 identical 0x33 -> bin 0x33 = 15 (saturated).
REQ-035 rst_n low for 1 cycle at pixel 30 -> sp_we 0 immediately, no writes until the next start, restart yields correct counts.
REQ-036 start pulsed during COUNT -> ignored; exactly one done.
REQ-037 HIST_CLEAR_EN, scratchpad preloaded 0xFFFF -> 256 clear writes precede counting; final bins match a fresh histogram.
